// File: rtl/dsm_adc_decim.sv
// dsm_adc_decim: second-order CIC (sinc^2) decimator that turns a 1-bit
// delta-sigma bitstream into unsigned 8-bit PCM, one sample per OSR
// accepted bits, flagged by a single-cycle pcm_valid strobe.
module dsm_adc_decim #(
  parameter int unsigned OSR         = 100,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned SCALE_MUL   = 1671,
  parameter int unsigned SCALE_SHIFT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dsm_in,
  output logic [7:0] pcm_out,
  output logic       pcm_valid
);

  // Product is kept wide enough for any 32-bit gain, so no bits are lost
  // before the shift.
  localparam int unsigned PW   = ACC_W + 32;
  localparam logic [7:0]  LAST = 8'(OSR - 1);

  // Integrators, comb delays and the registered comb result
  logic [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [ACC_W-1:0] c2_q, c2_d;
  logic [ACC_W-1:0] c1;

  // Frame counter and pipeline control
  logic [7:0] cnt_q, cnt_d;
  logic       s1_q, s1_d;   // comb stage runs on this edge
  logic       s2_q, s2_d;   // output stage runs on this edge
  logic       warm_q, warm_d;

  // Output registers
  logic [7:0] pcm_q, pcm_d;
  logic       vld_q, vld_d;

  logic [PW-1:0] prod, scaled;

  assign c1     = i2_q - d1_q;
  assign prod   = PW'(c2_q) * PW'(SCALE_MUL);
  assign scaled = prod >> SCALE_SHIFT;

  // Next-state logic: integrate accepted bits, detect frame end, run the
  // comb and output stages on the two edges that follow it.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    i1_d   = i1_q;
    i2_d   = i2_q;
    cnt_d  = cnt_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    c2_d   = c2_q;
    warm_d = warm_q;
    pcm_d  = pcm_q;
    vld_d  = 1'b0;
    s1_d   = 1'b0;
    s2_d   = s1_q;

    if (en) begin
      i1_d  = i1_q + ACC_W'(dsm_in);
      i2_d  = i2_q + i1_d;
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
      s1_d  = (cnt_q == LAST);
    end

    // Comb stage works on the integrator value latched at frame end; it is
    // independent of en so a stalled input never delays the pipeline.
    if (s1_q) begin
      d1_d = i2_q;
      d2_d = c1;
      c2_d = c1 - d2_q;
    end

    // Output stage: scale, saturate, and strobe once the delays hold a
    // real previous frame.
    if (s2_q) begin
      pcm_d  = (scaled > PW'(255)) ? 8'hFF : scaled[7:0];
      vld_d  = warm_q;
      warm_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q   <= '0;
      i2_q   <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      c2_q   <= '0;
      cnt_q  <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      warm_q <= 1'b0;
      pcm_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      c2_q   <= c2_d;
      cnt_q  <= cnt_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      warm_q <= warm_d;
      pcm_q  <= pcm_d;
      vld_q  <= vld_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = vld_q;

endmodule

// File: tb/tb_dsm_adc_decim.sv
// tb_dsm_adc_decim: self-checking bench for dsm_adc_decim. A window-sum
// model predicts every output cycle; directed phases pin latency and
// DC values with literal expectations.
module tb_dsm_adc_decim;

  localparam int OSR         = 100;
  localparam int SCALE_MUL   = 1671;
  localparam int SCALE_SHIFT = 16;

  typedef enum int {M_ZERO, M_ONES, M_ALT, M_RND} mode_t;

  typedef struct {
    int       due;
    int       val;
    bit       vld;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dsm_in;
  logic [7:0] pcm_out;
  logic       pcm_valid;

  int    checks = 0;
  int    errors = 0;
  mode_t mode   = M_ZERO;
  int    density = 50;

  // model state
  bit    hist[$];
  ev_t   evq[$];
  int    cyc = 0;
  int    exp_out = 0;
  bit    exp_valid = 1'b0;

  dsm_adc_decim #(
    .OSR(OSR), .ACC_W(16), .SCALE_MUL(SCALE_MUL), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dsm_in(dsm_in),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sinc^2 output as a triangular-weighted sum over the last 2*OSR bits.
  function automatic int model_pcm();
    longint c2 = 0;
    longint p;
    int n = hist.size();
    for (int d = 0; d < 2 * OSR && d < n; d++) begin
      int w = (d < OSR) ? d + 1 : 2 * OSR - 1 - d;
      if (hist[n - 1 - d]) c2 += w;
    end
    p = (c2 * SCALE_MUL) >>> SCALE_SHIFT;
    return (p > 255) ? 255 : int'(p);
  endfunction

  // Reference model: accepted-bit history plus a queue of scheduled outputs.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      hist.delete();
      evq.delete();
      exp_out   = 0;
      exp_valid = 1'b0;
    end else begin
      ev_t e;
      cyc++;
      exp_valid = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        e = evq.pop_front();
        exp_out   = e.val;
        exp_valid = e.vld;
      end
      if (en) begin
        hist.push_back(dsm_in);
        if (hist.size() % OSR == 0) begin
          e.due = cyc + 2;
          e.val = model_pcm();
          e.vld = (hist.size() / OSR) >= 2;
          evq.push_back(e);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("valid_vs_model", int'(pcm_valid), int'(exp_valid));
    check("pcm_vs_model", int'(pcm_out), exp_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      M_ZERO: dsm_in = 1'b0;
      M_ONES: dsm_in = 1'b1;
      M_ALT:  dsm_in = ~dsm_in;
      default: begin
        dsm_in = ($urandom_range(0, 99) < density);
        en     = ($urandom_range(0, 9) != 0);
      end
    endcase
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  // Count edges until pcm_valid; a budget overrun is a failed comparison.
  task automatic wait_strobe(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (pcm_valid) begin
        n = i;
        return;
      end
    end
    check("strobe_timeout", 0, 1);
  endtask

  initial begin
    int n, total;
    rst_n  = 1'b0;
    en     = 1'b1;
    dsm_in = 1'b0;

    // Reset held with active inputs: outputs stay clear.
    mode = M_ALT;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_pcm", int'(pcm_out), 0);
      check("rst_valid", int'(pcm_valid), 0);
    end

    // All ones: first strobe 2*OSR+2 after release, then every OSR at 254.
    mode = M_ONES;
    dsm_in = 1'b1;
    rst_n = 1'b1;
    wait_strobe(n);
    check("ones_first_latency", n, 202);
    check("ones_first_value", int'(pcm_out), 254);
    for (int k = 0; k < 3; k++) begin
      wait_strobe(n);
      check("ones_spacing", n, 100);
      check("ones_value", int'(pcm_out), 254);
    end

    // en low for 37 cycles mid-frame stretches that frame by 37.
    for (int i = 0; i < 20; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 37; i++) tick();
    en = 1'b1;
    wait_strobe(n);
    total = 57 + n;
    check("en_gap_spacing", total, 137);
    check("en_gap_value", int'(pcm_out), 254);

    // Mid-frame reset: interrupted frame never strobes, warm-up restarts.
    for (int i = 0; i < 48; i++) tick();
    do_reset(3);
    check("midrst_pcm", int'(pcm_out), 0);
    wait_strobe(n);
    check("midrst_latency", n, 202);
    check("midrst_value", int'(pcm_out), 254);

    // All zeros.
    mode = M_ZERO;
    do_reset(2);
    wait_strobe(n);
    check("zeros_latency", n, 202);
    check("zeros_value", int'(pcm_out), 0);

    // 50% alternating pattern.
    mode = M_ALT;
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      wait_strobe(n);
      check("alt_value", int'(pcm_out), 127);
    end

    // Randomised densities and enable gaps, with one reset mid-run.
    mode = M_RND;
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) density = $urandom_range(0, 100);
      if (i == 1337) do_reset(2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsm_adc_decim.md
Name: dsm_adc_decim

Overview:
- Second-order CIC (sinc^2) decimator that converts a 1-bit delta-sigma bitstream back into 8-bit PCM. It is the receive-side counterpart of dsm_dac.
- It is used in loop-back benches and as the front end of the bitstream ADC path. dsm_dac output feeds dsm_in directly, at the same clk.
- It emits one PCM sample per OSR accepted input bits, with a single-cycle valid strobe.

Parameters:
- OSR, 100, decimation ratio (input bits per output sample); legal range 2..255.
- ACC_W, 16, integrator/comb width; must satisfy 2^ACC_W > OSR^2. Arithmetic is modulo 2^ACC_W.
- SCALE_MUL, 1671, output gain multiplier (unsigned).
- SCALE_SHIFT, 16, right shift applied after the multiply.

Ports:
- clk  in  1  system clock; same clock as dsm_dac.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  input-accept enable; dsm_in is consumed only on edges where en=1.
- dsm_in  in  1  bitstream input; 1 maps to +1, 0 maps to 0.
- pcm_out  out  8  decimated PCM sample, unsigned.
- pcm_valid  out  1  one-cycle strobe; pcm_out is new on that cycle.

Behaviour:
- Reset (async assert, sync release): the following registers clear to 0:
  - integrators I1, I2
  - comb delays D1, D2
  - frame counter
  - warm-up flag
  - pcm_out = 8'd0, pcm_valid = 0
- Integrators: on each rising edge with en=1, I1 <= I1 + dsm_in and I2 <= I2 + I1_next, where I1_next is the updated I1. With en=0, I1, I2 and the counter hold.
- Frame counter: counts accepted bits 0..OSR-1, then wraps to 0. The edge that accepts count OSR-1 is the "frame end".
- Comb stage: registered, updated on the edge after a frame end (the stage-1 edge).
  - s = I2
  - c1 = s - D1
  - c2 = c1 - D2
  - then D1 <= s and D2 <= c1
- Output stage, on the edge after stage 1:
  - p = (c2 * SCALE_MUL) >> SCALE_SHIFT, computed at full product width (ACC_W+16 bits minimum)
  - pcm_out = min(p, 255)
  - pcm_valid = 1 for exactly that cycle
- Latency: pcm_valid rises 2 clk edges after the frame-end edge. These two stages run regardless of en.
- DC gain: c2 = OSR^2 * mean(dsm_in) in steady state.
  - Defaults, all ones: c2 = 10000, pcm_out = 254.
  - Defaults, 50% ones: c2 = 5000, pcm_out = 127.
- Warm-up: the first frame after reset still updates D1/D2 and pcm_out, but pcm_valid is suppressed. The first strobe follows frame 2.
- Wrap-around: I1/I2 overflow modulo 2^ACC_W is expected; comb subtraction is modulo the same width, so results are exact.
- en low across a frame end: stages 1 and 2 still complete on schedule. The next frame simply stretches by the number of en=0 cycles.
- Strobe spacing: pcm_valid never fires on two consecutive cycles; spacing is at least OSR cycles.
- rst_n asserted mid-frame or mid-pipeline:
  - all state clears immediately
  - any in-flight frame is discarded, with no strobe
  - warm-up applies again

Test Plan:
- Reset: rst_n=0 with en=1 and dsm_in toggling -> pcm_out=0, pcm_valid=0 throughout. Release -> first strobe exactly 2*OSR+2 = 202 cycles after release.
- DC extremes: dsm_in=1, en=1 held -> every strobe reads 254, strobes spaced 100 cycles. dsm_in=0 held -> every strobe reads 0.
- 50% pattern: dsm_in alternating 1,0 -> from the first valid strobe on, pcm_out=127.
- Loop-back: dsm_dac.dsm_in=8'd128, dsm_out wired to dsm_in, en=1 -> steady strobes read 127 +/-1. Then drive sin_gen through clk_div(100) as the dsm_dac input -> the PCM sequence tracks the sine with error <= 3 LSB after warm-up.
- Enable gating: constant all-ones, drop en for 37 cycles mid-frame -> that strobe is delayed by exactly 37 cycles and still reads 254.
- Mid-frame reset: pulse rst_n low for 3 cycles at frame count 50 -> no strobe for the interrupted frame. The next strobe appears 202 cycles after release and reads the correct value.
